print_sequencer: RTL and testbench

PRINT_SEQUENCER -- requirements
Module: print_sequencer

---
 rtl/print_pkg.sv | 20 ++
 rtl/print_fifo.sv | 67 ++++++
 rtl/print_sequencer.sv | 113 +++++++++++
 tb/tb_print_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/print_pkg.sv
// Shared types and constants for the print sequencer: FSM state encoding,
// default MMIO print addresses and the print-event decode.
package print_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } seq_state_e;

  localparam logic [31:0] DEFAULT_PRINT_ADR_1 = 32'h8000_0064;
  localparam logic [31:0] DEFAULT_PRINT_ADR_2 = 32'h0000_0000;

  function automatic logic is_print_event(input logic        wen,
                                          input logic [31:0] adr,
                                          input logic [31:0] adr_1,
                                          input logic [31:0] adr_2);
    return wen && ((adr == adr_1) || (adr == adr_2));
  endfunction

endpackage

// File: rtl/print_fifo.sv
// Power-of-two circular FIFO holding queued print values. Pop takes priority
// for room, so a push into a full FIFO succeeds when a pop shares the edge.
module print_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/print_sequencer.sv
// Captures CPU stores to the print addresses into a FIFO and shows each value
// on the display for HOLD_CYCLES cycles; skip cuts the current hold short.
module print_sequencer
  import print_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter int          HOLD_CYCLES = 50_000_000,
  parameter logic [31:0] PRINT_ADR_1 = DEFAULT_PRINT_ADR_1,
  parameter logic [31:0] PRINT_ADR_2 = DEFAULT_PRINT_ADR_2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MemoryAdr,
  input  logic [31:0] MemoryData,
  input  logic        wen,
  input  logic        skip,
  output logic [31:0] display_value,
  output logic        display_valid,
  output logic        fifo_full,
  output logic [7:0]  drop_count
);

  localparam int              HW     = $clog2(HOLD_CYCLES) + 1;
  localparam int              CW     = $clog2(DEPTH) + 1;
  localparam logic [HW-1:0]   RELOAD = HW'(HOLD_CYCLES - 1);

  seq_state_e    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [31:0]   disp_q, disp_d;
  logic          valid_q, valid_d;
  logic [7:0]    drop_q, drop_d;

  logic          print_event;
  logic          push, pop;
  logic [31:0]   fifo_rd_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_full_w, fifo_empty;

  assign print_event = is_print_event(wen, MemoryAdr, PRINT_ADR_1, PRINT_ADR_2);

  print_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (MemoryData),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full_w),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    disp_d     = disp_q;
    valid_d    = valid_q;
    drop_d     = drop_q;
    pop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          disp_d     = fifo_rd_data;
          valid_d    = 1'b1;
          hold_cnt_d = RELOAD;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if ((hold_cnt_q != '0) && !skip) begin
          hold_cnt_d = hold_cnt_q - HW'(1);
        end else if (!fifo_empty) begin
          pop        = 1'b1;
          disp_d     = fifo_rd_data;
          hold_cnt_d = RELOAD;
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    // A pop on this edge frees the slot the incoming print needs.
    push = print_event && (!fifo_full_w || pop);
    if (print_event && !push && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      disp_q     <= '0;
      valid_q    <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      disp_q     <= disp_d;
      valid_q    <= valid_d;
      drop_q     <= drop_d;
    end
  end

  assign display_value = disp_q;
  assign display_valid = valid_q;
  assign fifo_full     = (fifo_count == CW'(DEPTH));
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_print_sequencer.sv
// Directed bench for print_sequencer with DEPTH=4, HOLD_CYCLES=4; expected
// values are hand-derived cycle by cycle from the store/skip/reset stimulus.
module tb_print_sequencer;
  import print_pkg::*;

  localparam logic [31:0] ADR1 = 32'h8000_0064;
  localparam logic [31:0] ADR2 = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = 32'h0;
  logic [31:0] data = 32'h0;
  logic        wen = 1'b0;
  logic        skip = 1'b0;
  logic [31:0] display_value;
  logic        display_valid;
  logic        fifo_full;
  logic [7:0]  drop_count;

  int compared = 0;
  int mismatched = 0;

  print_sequencer #(
    .DEPTH       (4),
    .HOLD_CYCLES (4),
    .PRINT_ADR_1 (ADR1),
    .PRINT_ADR_2 (ADR2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .MemoryAdr     (adr),
    .MemoryData    (data),
    .wen           (wen),
    .skip          (skip),
    .display_value (display_value),
    .display_valid (display_valid),
    .fifo_full     (fifo_full),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    adr  = a;
    data = d;
    wen  = 1'b1;
  endtask

  task automatic bus_idle();
    wen  = 1'b0;
    adr  = 32'h0;
    data = 32'h0;
  endtask

  initial begin
    logic [31:0] exp_v;

    // Reset held across two edges.
    tick();
    tick();
    check("rst_value", display_value, 32'h0);
    check("rst_valid", 32'(display_valid), 32'h0);
    check("rst_full",  32'(fifo_full), 32'h0);
    check("rst_drop",  32'(drop_count), 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;

    // Single print: pushed at E, shown from E+1, held 4 cycles, then IDLE.
    store(ADR1, 32'h1234);
    tick();
    check("lat_not_yet", display_value, 32'h0);
    check("lat_valid0",  32'(display_valid), 32'h0);
    bus_idle();
    tick();
    check("single_value", display_value, 32'h1234);
    check("single_valid", 32'(display_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("single_hold_val", display_value, 32'h1234);
      check("single_hold_st",  32'(dut.state_q), 32'(HOLD));
    end
    tick();
    check("single_idle", 32'(dut.state_q), 32'(IDLE));
    check("single_keep", display_value, 32'h1234);

    // Three consecutive prints to the second address: 1,2,3 each for 4 cycles.
    for (int t = 0; t <= 12; t++) begin
      if (t < 3) store(ADR2, 32'(t + 1));
      else       bus_idle();
      tick();
      exp_v = (t == 0) ? 32'h1234 : 32'((t - 1) / 4 + 1);
      check("seq_value", display_value, exp_v);
    end
    tick();
    check("seq_idle", 32'(dut.state_q), 32'(IDLE));
    check("seq_last", display_value, 32'h3);

    // C0 goes straight to the display; C1..C6 follow back to back, C6 dropped.
    store(ADR1, 32'hC0);
    tick();
    for (int i = 0; i < 6; i++) begin
      store((i % 2 == 0) ? ADR1 : ADR2, 32'hC1 + 32'(i));
      tick();
      if (i == 0) check("ovf_first", display_value, 32'hC0);
    end
    bus_idle();
    check("ovf_value", display_value, 32'hC1);
    check("ovf_full",  32'(fifo_full), 32'h1);
    check("ovf_drop",  32'(drop_count), 32'h1);
    check("ovf_count", 32'(dut.u_fifo.count_q), 32'h4);
    for (int t = 6; t <= 24; t++) begin
      tick();
      if      (t < 8)  exp_v = 32'hC1;
      else if (t < 12) exp_v = 32'hC2;
      else if (t < 16) exp_v = 32'hC3;
      else if (t < 20) exp_v = 32'hC4;
      else             exp_v = 32'hC5;
      check("drain_value", display_value, exp_v);
      check("drain_full",  32'(fifo_full), (t < 8) ? 32'h1 : 32'h0);
    end
    check("drain_idle", 32'(dut.state_q), 32'(IDLE));

    // Non-print address and a print address without wen are ignored.
    store(32'h8000_0068, 32'hDEAD);
    tick();
    adr  = ADR1;
    data = 32'hBEEF;
    wen  = 1'b0;
    tick();
    bus_idle();
    tick();
    check("ign_value", display_value, 32'hC5);
    check("ign_count", 32'(dut.u_fifo.count_q), 32'h0);
    check("ign_state", 32'(dut.state_q), 32'(IDLE));
    check("ign_drop",  32'(drop_count), 32'h1);

    // Skip with counter at 2 and 0xAB queued brings 0xAB forward one edge later.
    store(ADR1, 32'h11);
    tick();
    store(ADR1, 32'hAB);
    tick();
    check("skip_pre", display_value, 32'h11);
    bus_idle();
    tick();
    check("skip_cnt2", 32'(dut.hold_cnt_q), 32'h2);
    skip = 1'b1;
    tick();
    skip = 1'b0;
    check("skip_value", display_value, 32'hAB);
    check("skip_count", 32'(dut.u_fifo.count_q), 32'h0);
    check("skip_reload", 32'(dut.hold_cnt_q), 32'h3);
    for (int i = 0; i < 4; i++) tick();
    check("skip_idle", 32'(dut.state_q), 32'(IDLE));
    skip = 1'b1;
    tick();
    tick();
    skip = 1'b0;
    check("idle_skip_state", 32'(dut.state_q), 32'(IDLE));
    check("idle_skip_value", display_value, 32'hAB);
    check("idle_skip_cnt",   32'(dut.hold_cnt_q), 32'h0);

    // Continuous prints overflow long enough to saturate the drop counter.
    for (int i = 0; i < 400; i++) begin
      store(ADR2, 32'(i));
      tick();
    end
    bus_idle();
    check("sat_drop", 32'(drop_count), 32'hFF);
    check("sat_full", 32'(fifo_full), 32'h1);
    rst = 1'b1;
    #1;
    check("sat_rst_drop", 32'(drop_count), 32'h0);
    check("sat_rst_full", 32'(fifo_full), 32'h0);
    tick();
    rst = 1'b0;

    // Asynchronous reset mid-HOLD with two entries queued.
    store(ADR1, 32'h31);
    tick();
    store(ADR1, 32'h32);
    tick();
    store(ADR1, 32'h33);
    tick();
    bus_idle();
    check("arst_pre_value", display_value, 32'h31);
    check("arst_pre_count", 32'(dut.u_fifo.count_q), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_value", display_value, 32'h0);
    check("arst_valid", 32'(display_valid), 32'h0);
    check("arst_full",  32'(fifo_full), 32'h0);
    check("arst_drop",  32'(drop_count), 32'h0);
    check("arst_state", 32'(dut.state_q), 32'(IDLE));
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("post_count", 32'(dut.u_fifo.count_q), 32'h0);
    check("post_value", display_value, 32'h0);
    check("post_valid", 32'(display_valid), 32'h0);
    check("post_state", 32'(dut.state_q), 32'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
